ap_ctrl_profiler: RTL and testbench

AP_CTRL_PROFILER -- requirements
Module: ap_ctrl_profiler

---
 rtl/ap_ctrl_profiler.sv | 164 ++++++++++++++++
 tb/tb_ap_ctrl_profiler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_ctrl_profiler.sv
// ap_ctrl_profiler: timestamps ap_ctrl transactions and streams latency records.
// Optional done-stall counting is built when AP_CTRL_PROFILER_STALL_EN is defined.
module ap_ctrl_profiler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             mon_ap_start,
    input  logic             mon_ap_ready,
    input  logic             mon_ap_done,
    input  logic             mon_ap_continue,
    input  logic             finish,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [CNT_W-1:0] rec_start,
    output logic [CNT_W-1:0] rec_latency,
    output logic [CNT_W-1:0] rec_interval,
    output logic [15:0]      rec_index,
    output logic [CNT_W-1:0] rec_stall,
    output logic             overflow,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [AW:0] PONE = (AW+1)'(1);

    typedef enum logic {ARMED, ACCEPTED} state_t;

    typedef struct packed {
`ifdef AP_CTRL_PROFILER_STALL_EN
        logic [CNT_W-1:0] stall;
`endif
        logic [CNT_W-1:0] start;
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] interval;
        logic [15:0]      index;
    } rec_t;

    state_t           state;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ts0;
    logic [CNT_W-1:0] ts1;
    logic [CNT_W-1:0] last_start;
    logic [1:0]       pcnt;
    logic [15:0]      idx;
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    rec_t             mem [DEPTH];
    rec_t             rec_new;
    rec_t             head;
    logic             start_ev;
    logic             comp;
    logic             take;
    logic             fifo_full;
    logic             fifo_pop;
    logic             fifo_push;
    logic             drop;

    assign start_ev  = (state == ARMED) && mon_ap_start && !finish;
    assign comp      = mon_ap_done && mon_ap_continue && (pcnt != 2'd0);
    // A same-cycle completion frees a slot, so a full queue can still take the start
    assign take      = start_ev && ((pcnt != 2'd2) || comp);
    assign fifo_full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    assign rec_valid = wptr != rptr;
    assign fifo_pop  = rec_valid && rec_ready;
    assign fifo_push = comp && (!fifo_full || fifo_pop);
    assign drop      = comp && fifo_full && !fifo_pop;
    assign busy      = (pcnt != 2'd0) || rec_valid;

`ifdef AP_CTRL_PROFILER_STALL_EN
    logic [CNT_W-1:0] st0;
    logic [CNT_W-1:0] st1;
    logic             stall_ev;

    assign stall_ev = mon_ap_done && !mon_ap_continue && (pcnt != 2'd0);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            st0 <= '0;
            st1 <= '0;
        end else if (comp) begin
            if (take && pcnt == 2'd1) begin
                st0 <= '0;
            end else begin
                st0 <= st1;
                if (take) st1 <= '0;
            end
        end else begin
            if (stall_ev) st0 <= st0 + ONE;
            if (take) begin
                if (pcnt == 2'd0) st0 <= '0;
                else              st1 <= '0;
            end
        end
    end
`endif

    always_comb begin
        rec_new          = '0;
        rec_new.start    = ts0;
        rec_new.latency  = cyc - ts0 + ONE;
        rec_new.interval = (idx == 16'd0) ? '0 : ts0 - last_start;
        rec_new.index    = idx;
`ifdef AP_CTRL_PROFILER_STALL_EN
        rec_new.stall    = st0;
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= ARMED;
            cyc        <= '0;
            ts0        <= '0;
            ts1        <= '0;
            last_start <= '0;
            pcnt       <= 2'd0;
            idx        <= 16'd0;
            overflow   <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
        end else begin
            cyc <= cyc + ONE;
            unique case (state)
                ARMED:    if (start_ev && !mon_ap_ready) state <= ACCEPTED;
                ACCEPTED: if (mon_ap_ready) state <= ARMED;
            endcase
            if ((start_ev && !take) || drop) overflow <= 1'b1;
            if (comp) begin
                if (take && pcnt == 2'd1) begin
                    ts0 <= cyc;
                end else begin
                    ts0 <= ts1;
                    if (take) ts1 <= cyc;
                end
                if (!take) pcnt <= pcnt - 2'd1;
                idx        <= idx + 16'd1;
                last_start <= ts0;
            end else if (take) begin
                if (pcnt == 2'd0) ts0 <= cyc;
                else              ts1 <= cyc;
                pcnt <= pcnt + 2'd1;
            end
            if (fifo_push) wptr <= wptr + PONE;
            if (fifo_pop)  rptr <= rptr + PONE;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (fifo_push) mem[wptr[AW-1:0]] <= rec_new;
    end

    assign head         = mem[rptr[AW-1:0]];
    assign rec_start    = rec_valid ? head.start    : '0;
    assign rec_latency  = rec_valid ? head.latency  : '0;
    assign rec_interval = rec_valid ? head.interval : '0;
    assign rec_index    = rec_valid ? head.index    : 16'd0;
`ifdef AP_CTRL_PROFILER_STALL_EN
    assign rec_stall    = rec_valid ? head.stall    : '0;
`else
    assign rec_stall    = '0;
`endif

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// tb_ap_ctrl_profiler: scoreboard bench for the ap_ctrl transaction profiler.
`timescale 1ns/1ps
module tb_ap_ctrl_profiler;
    localparam int CW    = 32;
    localparam int DEPTH = 4;

    logic          ap_clk          = 1'b0;
    logic          ap_rst_n        = 1'b0;
    logic          mon_ap_start    = 1'b0;
    logic          mon_ap_ready    = 1'b0;
    logic          mon_ap_done     = 1'b0;
    logic          mon_ap_continue = 1'b0;
    logic          finish          = 1'b0;
    logic          rec_ready       = 1'b0;
    logic          rec_valid;
    logic          overflow;
    logic          busy;
    logic [CW-1:0] rec_start;
    logic [CW-1:0] rec_latency;
    logic [CW-1:0] rec_interval;
    logic [CW-1:0] rec_stall;
    logic [15:0]   rec_index;

    ap_ctrl_profiler #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .mon_ap_start    (mon_ap_start),
        .mon_ap_ready    (mon_ap_ready),
        .mon_ap_done     (mon_ap_done),
        .mon_ap_continue (mon_ap_continue),
        .finish          (finish),
        .rec_valid       (rec_valid),
        .rec_ready       (rec_ready),
        .rec_start       (rec_start),
        .rec_latency     (rec_latency),
        .rec_interval    (rec_interval),
        .rec_index       (rec_index),
        .rec_stall       (rec_stall),
        .overflow        (overflow),
        .busy            (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [CW-1:0] st;
        logic [CW-1:0] lat;
        logic [CW-1:0] itv;
        logic [15:0]   idx;
        logic [CW-1:0] stall;
    } exp_t;

    typedef struct {
        int gap;
        int rdy_dly;
        int dur;
        int cont_dly;
        int exp_lat;
    } vec_t;

    exp_t          sb[$];
    exp_t          got;
    logic [CW-1:0] pend[$];
    vec_t          vecs[6];
    int            checks = 0;
    int            passed = 0;
    int            now    = 0;
    logic [CW-1:0] prev_st = '0;
    logic [15:0]   nidx    = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
        now++;
    endtask

    task automatic idle_until(input int n);
        while (now < n) tick();
    endtask

    task automatic start_txn(input int rdy_dly, input bit track);
        if (track) pend.push_back(CW'(now));
        for (int k = 0; k <= rdy_dly; k++) begin
            mon_ap_start = 1'b1;
            mon_ap_ready = (k == rdy_dly);
            tick();
        end
        mon_ap_start = 1'b0;
        mon_ap_ready = 1'b0;
    endtask

    task automatic complete(input int cont_dly, input int exp_lat, input bit keep);
        exp_t          e;
        logic [CW-1:0] s;
        for (int k = 0; k < cont_dly; k++) begin
            mon_ap_done     = 1'b1;
            mon_ap_continue = 1'b0;
            tick();
        end
        mon_ap_done     = 1'b1;
        mon_ap_continue = 1'b1;
        s     = pend.pop_front();
        e.st  = s;
        e.lat = CW'(exp_lat);
        e.itv = (nidx == 16'd0) ? '0 : s - prev_st;
        e.idx = nidx;
`ifdef AP_CTRL_PROFILER_STALL_EN
        e.stall = CW'(cont_dly);
`else
        e.stall = '0;
`endif
        prev_st = s;
        nidx++;
        if (keep) sb.push_back(e);
        tick();
        mon_ap_done     = 1'b0;
        mon_ap_continue = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 40 && sb.size() != 0; k++) tick();
        chk(name, sb.size(), 0);
    endtask

    task automatic reset_dut();
        ap_rst_n        = 1'b0;
        mon_ap_start    = 1'b0;
        mon_ap_ready    = 1'b0;
        mon_ap_done     = 1'b0;
        mon_ap_continue = 1'b0;
        finish          = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        now      = 0;
        pend.delete();
        prev_st  = '0;
        nidx     = '0;
    endtask

    always @(negedge ap_clk) begin
        if (ap_rst_n && rec_valid && rec_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_record: got index %0d, expected none", rec_index);
            end else begin
                got = sb.pop_front();
                chk("rec_start", rec_start, got.st);
                chk("rec_latency", rec_latency, got.lat);
                chk("rec_interval", rec_interval, got.itv);
                chk("rec_index", rec_index, got.idx);
                chk("rec_stall", rec_stall, got.stall);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 1, 0, 2};
        vecs[1] = '{2, 1, 5, 0, 6};
        vecs[2] = '{1, 0, 3, 4, 8};
        vecs[3] = '{0, 3, 4, 0, 5};
        vecs[4] = '{3, 0, 10, 2, 13};
        vecs[5] = '{0, 2, 3, 1, 5};

        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_valid", rec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_start", rec_start, 0);
        chk("rst_index", rec_index, 0);
        ap_rst_n  = 1'b1;
        now       = 0;
        rec_ready = 1'b1;

        // Single transaction: start 10, done 25
        idle_until(10);
        start_txn(0, 1);
        chk("busy_pending", busy, 1);
        idle_until(25);
        complete(0, 16, 1);
        wait_drain("drain_single");

        // Pipelined starts at 3 and 4, done at 20 and 21
        reset_dut();
        idle_until(3);
        mon_ap_start = 1'b1;
        mon_ap_ready = 1'b1;
        pend.push_back(CW'(now));
        tick();
        pend.push_back(CW'(now));
        tick();
        mon_ap_start = 1'b0;
        mon_ap_ready = 1'b0;
        idle_until(20);
        complete(0, 18, 1);
        complete(0, 18, 1);
        wait_drain("drain_pipelined");

        foreach (vecs[i]) begin
            repeat (vecs[i].gap) tick();
            start_txn(vecs[i].rdy_dly, 1);
            chk("busy_vec", busy, 1);
            repeat (vecs[i].dur - vecs[i].rdy_dly - 1) tick();
            complete(vecs[i].cont_dly, vecs[i].exp_lat, 1);
        end
        wait_drain("drain_table");

        // Start in the same cycle as a completion
        start_txn(0, 1);
        tick();
        mon_ap_start = 1'b1;
        mon_ap_ready = 1'b1;
        pend.push_back(CW'(now));
        complete(0, 3, 1);
        mon_ap_start = 1'b0;
        mon_ap_ready = 1'b0;
        tick();
        complete(0, 3, 1);
        wait_drain("drain_overlap");

        // Completion with nothing pending is ignored
        mon_ap_done     = 1'b1;
        mon_ap_continue = 1'b1;
        repeat (2) tick();
        mon_ap_done     = 1'b0;
        mon_ap_continue = 1'b0;
        repeat (3) tick();
        chk("spurious_valid", rec_valid, 0);
        chk("spurious_busy", busy, 0);

        // FIFO overflow with rec_ready low
        reset_dut();
        rec_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            start_txn(0, 1);
            tick();
            if (i == 5) rec_ready = 1'b1;
            complete(0, 3, i != 4);
            if (i == 5) rec_ready = 1'b0;
            if (i == 3) begin
                tick();
                chk("ovf_at_full", overflow, 0);
            end
            if (i == 4) begin
                tick();
                chk("ovf_set", overflow, 1);
                chk("ovf_valid", rec_valid, 1);
                chk("ovf_head_index", rec_index, 0);
            end
        end
        tick();
        rec_ready = 1'b1;
        wait_drain("drain_overflow");
        chk("ovf_sticky", overflow, 1);

        // finish suppresses new starts but lets pending work drain
        start_txn(0, 1);
        finish       = 1'b1;
        mon_ap_start = 1'b1;
        mon_ap_ready = 1'b1;
        tick();
        mon_ap_start = 1'b0;
        mon_ap_ready = 1'b0;
        chk("finish_busy", busy, 1);
        tick();
        complete(0, 4, 1);
        wait_drain("drain_finish");
        start_txn(0, 0);
        mon_ap_done     = 1'b1;
        mon_ap_continue = 1'b1;
        tick();
        mon_ap_done     = 1'b0;
        mon_ap_continue = 1'b0;
        repeat (3) tick();
        chk("finish_idle_busy", busy, 0);
        chk("finish_idle_valid", rec_valid, 0);
        finish = 1'b0;

        // Reset mid-transaction
        reset_dut();
        rec_ready = 1'b0;
        start_txn(0, 1);
        start_txn(0, 1);
        start_txn(0, 0);
        chk("pend_ovf", overflow, 1);
        complete(0, 0, 0);
        complete(0, 0, 0);
        start_txn(0, 1);
        tick();
        chk("pre_rst_valid", rec_valid, 1);
        chk("pre_rst_busy", busy, 1);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rec_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_overflow", overflow, 0);
        chk("async_rst_start", rec_start, 0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        now      = 0;
        pend.delete();
        prev_st  = '0;
        nidx     = '0;
        rec_ready = 1'b1;
        repeat (4) tick();
        mon_ap_done     = 1'b1;
        mon_ap_continue = 1'b1;
        repeat (2) tick();
        mon_ap_done     = 1'b0;
        mon_ap_continue = 1'b0;
        repeat (4) tick();
        chk("post_rst_valid", rec_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_overflow", overflow, 0);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
